// File: rtl/riscv_mem_pkg.sv
// Shared load/store definitions: size encodings, responder FSM states, byte-enable derivation.
// Used by the data-memory responder and by any future fetch-side responder.
package riscv_mem_pkg;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Offending low address bits are simply ignored here; misalignment is judged elsewhere.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            MEM_SIZE_BYTE: be = 4'b0001 << addr_lo;
            MEM_SIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:       be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            MEM_SIZE_BYTE: bad = 1'b0;
            MEM_SIZE_HALF: bad = addr_lo[0];
            MEM_SIZE_WORD: bad = |addr_lo;
            default:       bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM stage (master) and the data-memory responder (slave).
// resp_err exists only when DMEM_MISALIGN_CHECK_EN is defined.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
`ifdef DMEM_MISALIGN_CHECK_EN
    logic        resp_err;
`endif

    modport master (
        output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata
`ifdef DMEM_MISALIGN_CHECK_EN
        , input resp_err
`endif
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata
`ifdef DMEM_MISALIGN_CHECK_EN
        , output resp_err
`endif
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: replicates store data into all lanes and right-aligns plus
// sign/zero-extends load data. Half uses addr_lo[1] only; word ignores addr_lo.
module dmem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [31:0] store_lanes,
    output logic [31:0] load_data
);
    logic [31:0] shifted;

    always_comb begin
        store_lanes = store_data;
        case (size)
            MEM_SIZE_BYTE: store_lanes = {4{store_data[7:0]}};
            MEM_SIZE_HALF: store_lanes = {2{store_data[15:0]}};
            default:       store_lanes = store_data;
        endcase
    end

    always_comb begin
        shifted   = load_word;
        load_data = load_word;
        case (size)
            MEM_SIZE_BYTE: begin
                shifted   = load_word >> {addr_lo, 3'b000};
                load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            end
            MEM_SIZE_HALF: begin
                shifted   = load_word >> {addr_lo[1], 4'b0000};
                load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            end
            default: load_data = load_word;
        endcase
    end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed LATENCY, byte-lane writes and load extension.
// Define DMEM_MISALIGN_CHECK_EN to flag misaligned/reserved-size accesses on resp_err.
//
// state   | meaning
// IDLE    | ready for a request
// WAIT    | request latched, latency counter running
// RESP    | response held until resp_ready
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               reset,
    dmem_responder_if.slave    bus,
    output logic               busy
);
    state_t state, state_d;
    logic [3:0] cnt, cnt_d;
    logic       accept, exec;

    logic              q_write, q_unsigned;
    logic [1:0]        q_size;
    logic [ADDR_W+1:0] q_addr;
    logic [31:0]       q_wdata;

    logic              acc_write, acc_unsigned, acc_err;
    logic [1:0]        acc_size;
    logic [ADDR_W+1:0] acc_addr;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_be;
    logic [31:0]       rd_word, store_lanes, load_data;
    logic [31:0]       mem [2**ADDR_W];

    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        accept  = 1'b0;
        exec    = 1'b0;
        case (state)
            ST_IDLE: if (bus.req_valid) begin
                accept = 1'b1;
                if (LATENCY == 1) begin
                    exec    = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    exec    = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: if (bus.resp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // With LATENCY==1 the access runs on the accept edge, so it must see the live request.
    always_comb begin
        if (state == ST_IDLE) begin
            acc_write    = bus.req_write;
            acc_unsigned = bus.req_unsigned;
            acc_size     = bus.req_size;
            acc_addr     = bus.req_addr[ADDR_W+1:0];
            acc_wdata    = bus.req_wdata;
        end else begin
            acc_write    = q_write;
            acc_unsigned = q_unsigned;
            acc_size     = q_size;
            acc_addr     = q_addr;
            acc_wdata    = q_wdata;
        end
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    assign acc_err = misaligned(acc_size, acc_addr[1:0]);
`else
    assign acc_err = 1'b0;
`endif

    assign acc_be  = byte_en(acc_size, acc_addr[1:0]);
    assign rd_word = mem[acc_addr[ADDR_W+1:2]];

    dmem_lane_align u_align (
        .size        (acc_size),
        .addr_lo     (acc_addr[1:0]),
        .is_unsigned (acc_unsigned),
        .store_data  (acc_wdata),
        .load_word   (rd_word),
        .store_lanes (store_lanes),
        .load_data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (exec && acc_write && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) mem[acc_addr[ADDR_W+1:2]][8*i +: 8] <= store_lanes[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            q_write        <= 1'b0;
            q_unsigned     <= 1'b0;
            q_size         <= '0;
            q_addr         <= '0;
            q_wdata        <= '0;
            bus.resp_rdata <= '0;
`ifdef DMEM_MISALIGN_CHECK_EN
            bus.resp_err   <= 1'b0;
`endif
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (accept) begin
                q_write    <= bus.req_write;
                q_unsigned <= bus.req_unsigned;
                q_size     <= bus.req_size;
                q_addr     <= bus.req_addr[ADDR_W+1:0];
                q_wdata    <= bus.req_wdata;
            end
            if (exec) begin
                bus.resp_rdata <= (acc_write || acc_err) ? 32'h0 : load_data;
`ifdef DMEM_MISALIGN_CHECK_EN
                bus.resp_err   <= acc_err;
`endif
            end
        end
    end

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.resp_valid = (state == ST_RESP);
    assign busy           = (state != ST_IDLE);
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (ADDR_W=10, LATENCY=2) with hand-computed expected values.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy;
    int   vectors = 0;
    int   miscompares = 0;

    dmem_responder_if bus ();

    dmem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic get_err();
`ifdef DMEM_MISALIGN_CHECK_EN
        return bus.resp_err;
`else
        return 1'b0;
`endif
    endfunction

    // One complete transaction; starts and ends at a falling edge with the responder idle.
    task automatic txn(input string tag, input logic w, input logic [31:0] a, input logic [1:0] sz,
                       input logic u, input logic [31:0] wd, output logic [31:0] rd, output logic er);
        check({tag, "_ready"}, bus.req_ready, 1'b1);
        bus.req_write    = w;
        bus.req_addr     = a;
        bus.req_size     = sz;
        bus.req_unsigned = u;
        bus.req_wdata    = wd;
        bus.req_valid    = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check({tag, "_wait_valid"}, bus.resp_valid, 1'b0);
        check({tag, "_wait_busy"}, busy, 1'b1);
        @(negedge clk);
        check({tag, "_lat_valid"}, bus.resp_valid, 1'b1);
        rd = bus.resp_rdata;
        er = get_err();
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check({tag, "_done_valid"}, bus.resp_valid, 1'b0);
    endtask

    logic [31:0] rd, held;
    logic        er;

    initial begin
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_resp_valid", bus.resp_valid, 1'b0);
        check("rst_rdata", bus.resp_rdata, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", get_err(), 1'b0);
        reset = 1'b1;
        @(negedge clk);

        // Word store then load
        txn("st_w10", 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, rd, er);
        check("st_w10_rdata", rd, 32'h0);
        txn("ld_w10", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, er);
        check("ld_w10_rdata", rd, 32'hDEADBEEF);
        check("ld_w10_err", er, 1'b0);

        // Byte lane write and extension
        txn("st_b13", 1'b1, 32'h13, 2'b00, 1'b0, 32'h00000080, rd, er);
        txn("ld_b13s", 1'b0, 32'h13, 2'b00, 1'b0, 32'h0, rd, er);
        check("ld_b13s_rdata", rd, 32'hFFFFFF80);
        txn("ld_b13u", 1'b0, 32'h13, 2'b00, 1'b1, 32'h0, rd, er);
        check("ld_b13u_rdata", rd, 32'h00000080);
        txn("ld_w10b", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, er);
        check("ld_w10b_rdata", rd, 32'h80ADBEEF);

        // Response backpressure with a second request waiting
        bus.req_write = 1'b0; bus.req_addr = 32'h10; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("bp_valid0", bus.resp_valid, 1'b1);
        held = bus.resp_rdata;
        check("bp_rdata0", held, 32'h80ADBEEF);
        bus.req_write = 1'b0; bus.req_addr = 32'h12; bus.req_size = 2'b01; bus.req_unsigned = 1'b1;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", bus.resp_valid, 1'b1);
            check("bp_rdata", bus.resp_rdata, 32'h80ADBEEF);
            check("bp_req_ready", bus.req_ready, 1'b0);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("bp_after_hs_valid", bus.resp_valid, 1'b0);
        check("bp_after_hs_ready", bus.req_ready, 1'b1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("bp_accept_busy", busy, 1'b1);
        check("bp_accept_ready", bus.req_ready, 1'b0);
        @(negedge clk);
        check("bp_ld_h12_valid", bus.resp_valid, 1'b1);
        check("bp_ld_h12_rdata", bus.resp_rdata, 32'h000080AD);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;

        // Address wrap: (4<<10)+0x10 aliases word 4
        txn("st_h_wrap", 1'b1, (32'd4 << 10) + 32'h10, 2'b01, 1'b0, 32'h00001234, rd, er);
        txn("ld_h10", 1'b0, 32'h10, 2'b01, 1'b0, 32'h0, rd, er);
        check("ld_h10_rdata", rd, 32'h00001234);
        txn("ld_w10c", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, er);
        check("ld_w10c_rdata", rd, 32'h80AD1234);

        // Reset during WAIT of a store aborts it
        txn("st_w20", 1'b1, 32'h20, 2'b10, 1'b0, 32'h11223344, rd, er);
        bus.req_write = 1'b1; bus.req_addr = 32'h20; bus.req_size = 2'b10; bus.req_wdata = 32'hCAFEF00D;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("abort_busy_pre", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("abort_resp_valid", bus.resp_valid, 1'b0);
        check("abort_req_ready", bus.req_ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        txn("ld_w20", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, rd, er);
        check("ld_w20_rdata", rd, 32'h11223344);

        // Misaligned word store to 0x22
        txn("st_w22", 1'b1, 32'h22, 2'b10, 1'b0, 32'h55667788, rd, er);
`ifdef DMEM_MISALIGN_CHECK_EN
        check("st_w22_err", er, 1'b1);
        txn("ld_w20b", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, rd, er);
        check("ld_w20b_rdata", rd, 32'h11223344);
        txn("ld_rsv20", 1'b0, 32'h20, 2'b11, 1'b0, 32'h0, rd, er);
        check("ld_rsv20_err", er, 1'b1);
        check("ld_rsv20_rdata", rd, 32'h0);
`else
        check("st_w22_err", er, 1'b0);
        txn("ld_w20b", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, rd, er);
        check("ld_w20b_rdata", rd, 32'h55667788);
        txn("ld_rsv20", 1'b0, 32'h20, 2'b11, 1'b0, 32'h0, rd, er);
        check("ld_rsv20_rdata", rd, 32'h55667788);
        txn("ld_h23", 1'b0, 32'h23, 2'b01, 1'b0, 32'h0, rd, er);
        check("ld_h23_rdata", rd, 32'h00005566);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the pipeline's MEM-stage load/store requests. It is the other end of the request interface that the MEM stage initiates.
- Holds a word-organised data array and serves one outstanding request at a time.
- Access latency is fixed and parameterised.
- Handles byte-lane writes and sign/zero extension of loads, so the pipeline receives register-ready data.

Parameters:
ADDR_W, 10, word-address width; the array holds 2**ADDR_W 32-bit words.
LATENCY, 2, cycles from request acceptance to resp_valid; legal range 1..15.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_write  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  response present
resp_ready  input  1  pipeline accepts the response
resp_rdata  output  32  extended load data; 0 for stores
resp_err  output  1  misaligned/reserved-size flag; present only with the macro
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE, latency counter = 0, all latched request fields = 0.
  - Outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
  - Array contents are not reset.
- Reset asserted mid-operation aborts the access. A pending store that has not yet been committed is never written.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready, latch write, addr, size, unsigned and wdata.
  - Then go to WAIT with counter = LATENCY-1, or directly to RESP if LATENCY==1.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - When counter==1, the access executes on that clock edge and the state moves to RESP.
- Access execution:
  - Word index = addr[ADDR_W+1:2]. Upper address bits are ignored, so accesses wrap modulo array size.
  - Store: byte enables come from size and addr[1:0]; wdata is replicated into the selected lanes; unselected lanes are unchanged.
  - Load: read the word, shift the selected lane to bit 0, then sign- or zero-extend per req_unsigned.
  - The result is registered into resp_rdata.
- RESP:
  - resp_valid=1; resp_rdata and resp_err stay stable until resp_ready.
  - On resp_valid && resp_ready, go to IDLE. req_ready rises the following cycle; back-to-back requests are not overlapped.
- Timing: request accepted at edge N, resp_valid high from cycle N+LATENCY onward. The request-to-request minimum is LATENCY+1 cycles.
- req_valid while busy is ignored; the requester holds it.
- The responder does not inspect the request fields for stability.
- Reserved size 11 is treated as word, except as specified under the optional feature.

Optional Feature:
Macro DMEM_MISALIGN_CHECK_EN.
- Defined:
  - resp_err=1 for a half access with addr[0]=1, a word access with addr[1:0]!=0, or size=11.
  - A flagged store does not modify the array; a flagged load returns resp_rdata=0.
  - Latency is unchanged.
- Undefined:
  - No resp_err port.
  - The offending low address bits are masked: half uses addr[1], word ignores addr[1:0].
  - Size 11 is treated as word.

Decomposition:
- Shared package riscv_mem_pkg holds:
  - size encodings MEM_SIZE_BYTE/HALF/WORD;
  - the FSM state enum;
  - the byte-enable derivation function.
- One sub-module, dmem_lane_align: a combinational store-lane replication plus load shift/extend block, reusable by a future instruction-fetch responder.

Test Plan:
1. Reset, LATENCY=2: store word 0xDEADBEEF to 0x10, then load word 0x10 → resp_valid 2 cycles after each accept; rdata 0xDEADBEEF.
2. Store byte 0x80 to 0x13, then load byte signed 0x13 → 0xFFFFFF80. Load unsigned → 0x00000080. Load word 0x10 → 0x80ADBEEF.
3. Hold resp_ready low for 5 cycles → resp_valid and rdata stable, req_ready=0 throughout; a req_valid presented in that window is not accepted until one cycle after the handshake.
4. Store half 0x1234 to address (4<<ADDR_W)+0x10 → aliases word 4, so a load half from 0x10 returns 0x00001234.
5. Assert reset low during WAIT of a store to 0x20 → resp_valid=0 and req_ready=1 immediately; a later load of 0x20 returns the prior contents.
6. With DMEM_MISALIGN_CHECK_EN, word store to 0x22 → resp_err=1 and memory unchanged. Without the macro, the same store writes word 8 (0x20).
